// File: rtl/pwm_basico.sv
// pwm_basico: free-running PWM with a self-sweeping duty cycle.
// The R-bit counter sets the PWM period (2^R clocks). `enable` ticks for one
// clock at the end of every period. Duty steps once every DIV periods.
// Optional feature: define PWM_BASICO_BREATHE_EN for a triangle ("breathing")
// sweep. Without it the sweep is a sawtooth that wraps from max back to 0.
module pwm_basico #(
  parameter int R   = 8,
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic enable,
  output logic pwm_out
);

  localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [R-1:0]    CNT_MAX   = '1;
  localparam logic [PW-1:0]   PCNT_LAST = PW'(DIV - 1);

  logic [R-1:0]  cnt;
  logic [R-1:0]  cnt_next;
  logic [R-1:0]  duty;
  logic [R-1:0]  duty_next;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_next;
  logic          step;

`ifdef PWM_BASICO_BREATHE_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  dir_t dir;
  dir_t dir_next;
`endif

  assign cnt_next = cnt + R'(1);
  assign enable   = (cnt == CNT_MAX);
  assign step     = enable && (pcnt == PCNT_LAST);

  // Period counter: advances on each end-of-period tick, clears at a duty step
  always_comb begin
    pcnt_next = pcnt;
    if (enable) begin
      pcnt_next = step ? '0 : pcnt + PW'(1);
    end
  end

`ifdef PWM_BASICO_BREATHE_EN
  // Triangle sweep: direction flips on the step that lands on either end
  always_comb begin
    duty_next = duty;
    dir_next  = dir;
    if (step) begin
      if (dir == DIR_UP) begin
        duty_next = duty + R'(1);
        if (duty_next == CNT_MAX) dir_next = DIR_DOWN;
      end else begin
        duty_next = duty - R'(1);
        if (duty_next == '0) dir_next = DIR_UP;
      end
    end
  end

  // Direction register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dir <= DIR_UP;
    else       dir <= dir_next;
  end
`else
  // Sawtooth sweep: natural R-bit wrap from max back to 0
  always_comb begin
    duty_next = duty;
    if (step) duty_next = duty + R'(1);
  end
`endif

  // Counter, period counter, duty and registered PWM output.
  // The compare uses duty_next: a step only happens on the wrap edge, so the
  // new duty governs the whole period that starts there and no runt appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pcnt    <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      pcnt    <= pcnt_next;
      duty    <= duty_next;
      pwm_out <= (cnt_next < duty_next);
    end
  end

endmodule

// File: tb/tb_pwm_basico.sv
// Scoreboard bench for pwm_basico. Expected per-period high counts come from
// the duty sweep sequence; a monitor measures each period and compares.
module tb_pwm_basico;

  localparam int R    = 4;
  localparam int DIV  = 3;
  localparam int PER  = 1 << R;
  localparam int DMAX = PER - 1;
  localparam int NPER = 100;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic pwm_out;

  int errors = 0;
  int checks = 0;

  int exp_q[$];
  bit mon_on = 1'b0;
  int nper   = 0;

  pwm_basico #(.R(R), .DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  // Expected duty during period j (0-based) counted from reset release
  function automatic int exp_duty(int j);
    int s;
    int t;
    s = j / DIV;
`ifdef PWM_BASICO_BREATHE_EN
    t = s % (2 * DMAX);
    return (t <= DMAX) ? t : (2 * DMAX - t);
`else
    t = s % PER;
    return t;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_seq(input int n);
    for (int j = 0; j < n; j++) exp_q.push_back(exp_duty(j));
  endtask

  // Monitor: samples 2 time units after each rising edge
  initial begin
    int clk_cnt;
    int last_en;
    int hi;
    bit seen_low;
    bit runt;
    bit first_en;
    forever begin
      @(posedge clk);
      #2;
      if (!mon_on) begin
        clk_cnt = 0; last_en = 0; hi = 0;
        seen_low = 0; runt = 0; first_en = 1;
        continue;
      end
      clk_cnt++;
      if (pwm_out) begin
        if (seen_low) runt = 1;
        hi++;
      end else begin
        seen_low = 1;
      end
      if (enable) begin
        check(first_en ? "first_enable" : "enable_spacing",
              clk_cnt - last_en, first_en ? PER - 1 : PER);
        if (exp_q.size() > 0) begin
          check("pulse_width", hi, exp_q.pop_front());
          check("no_runt", int'(runt), 0);
        end
        hi = 0; seen_low = 0; runt = 0;
        last_en = clk_cnt; first_en = 0;
        nper++;
      end else if (clk_cnt - last_en > 2 * PER) begin
        check("enable_timeout", clk_cnt - last_en, PER);
        last_en = clk_cnt;
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_pwm", int'(pwm_out), 0);
      check("reset_enable", int'(enable), 0);
    end

    // Run through the full sweep wrap (sawtooth) or full breath (triangle)
    push_seq(NPER + 20);
    nper = 0;
    @(negedge clk);
    reset  = 1'b0;
    mon_on = 1'b1;
    guard  = 0;
    while (nper < NPER && guard < NPER * PER + 100) begin
      @(negedge clk);
      guard++;
    end
    check("run1_periods", nper >= NPER ? NPER : nper, NPER);

    // Async reset mid-period while pwm_out is high
    guard = 0;
    @(negedge clk);
    while (!pwm_out && guard < 4 * DIV * PER) begin
      @(negedge clk);
      guard++;
    end
    check("pwm_high_seen", int'(pwm_out), 1);
    #1;
    reset  = 1'b1;
    mon_on = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm_out), 0);
    check("async_reset_enable", int'(enable), 0);
    repeat (2) @(negedge clk);
    check("held_reset_pwm", int'(pwm_out), 0);

    // After release the sequence restarts from scratch
    exp_q.delete();
    push_seq(2 * DIV + 10);
    nper = 0;
    @(negedge clk);
    reset  = 1'b0;
    mon_on = 1'b1;
    guard  = 0;
    while (nper < 2 * DIV + 4 && guard < 20 * PER) begin
      @(negedge clk);
      guard++;
    end
    check("run2_periods", nper >= 2 * DIV + 4 ? 2 * DIV + 4 : nper, 2 * DIV + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
